// File: rtl/fpu_sequencer_if.sv
// Operand-in, FPU-drive and result-out signals of fpu_sequencer.
// The sequencer takes the slave view; a producer/consumer/FPU model takes the master view.
`timescale 1ns/1ps
interface fpu_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic [31:0]   op_a_out;
  logic [31:0]   op_b_out;
  logic [31:0]   fpu_data_in;
  logic [3:0]    fpu_status_in;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic [3:0]    res_status;
  logic          busy;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_a, in_b, fpu_data_in, fpu_status_in, res_ready,
    output in_ready, op_a_out, op_b_out, res_valid, res_data, res_status, busy, count
  );

  modport master (
    output in_valid, in_a, in_b, fpu_data_in, fpu_status_in, res_ready,
    input  in_ready, op_a_out, op_b_out, res_valid, res_data, res_status, busy, count
  );
endinterface

// File: rtl/fpu_sequencer.sv
// Queues operand pairs, holds each pair on a free-running FPU for HOLD_CYCLES cycles,
// then captures the FPU result and offers it on a valid/ready output.
`timescale 1ns/1ps
module fpu_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 64
) (
  input logic          clock100KHz,
  input logic          reset,
  fpu_sequencer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, OUT} state_t;

  logic [63:0]   fifo_mem [DEPTH];

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    timer_q, timer_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [3:0]    res_status_q, res_status_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, busy_d;

  logic full;
  logic push;
  logic pop;

  assign full = (count_q == CW'(DEPTH));
  assign push = bus.in_valid && !full;
  // Pops are only ever launched from IDLE, so the pop decision uses the count at cycle start.
  assign pop  = (state_q == IDLE) && (count_q != '0);

  always_ff @(posedge clock100KHz) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.in_a, bus.in_b};
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    timer_d      = timer_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_data_d   = res_data_q;
    res_status_d = res_status_q;
    res_valid_d  = res_valid_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      op_a_d   = fifo_mem[rd_ptr_q][63:32];
      op_b_d   = fifo_mem[rd_ptr_q][31:0];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // HOLD_CYCLES-2 plus the ISSUE and final zero-timer cycles lands capture HOLD_CYCLES after the pop.
        timer_d = 8'(HOLD_CYCLES - 2);
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q == 8'd0) begin
          state_d = CAPTURE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      CAPTURE: begin
        res_data_d   = bus.fpu_data_in;
        res_status_d = bus.fpu_status_in;
        res_valid_d  = 1'b1;
        state_d      = OUT;
      end
      OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      res_data_q   <= '0;
      res_status_q <= '0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      res_data_q   <= res_data_d;
      res_status_q <= res_status_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.op_a_out   = op_a_q;
  assign bus.op_b_out   = op_b_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_status = res_status_q;
  assign bus.busy       = busy_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: latency, fill/full, backpressure, ordering, same-edge push/pop, reset.
`timescale 1ns/1ps
module tb_fpu_sequencer;
  localparam int DEPTH = 4;
  localparam int HOLD  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   results_seen = 0;
  int   max_count = 0;
  logic [63:0] sb [$];

  fpu_sequencer_if #(.DEPTH(DEPTH)) bus();

  fpu_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clock100KHz (clk),
    .reset       (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Free-running FPU model: A==B gives 0x42000000 "exact" for the 2.0+2.0 case.
  function automatic logic [31:0] fpu_res(input logic [31:0] a, input logic [31:0] b);
    return a ^ b ^ 32'h4200_0000;
  endfunction
  function automatic logic [3:0] fpu_stat(input logic [31:0] a, input logic [31:0] b);
    return (a == b) ? 4'b0001 : 4'b0010;
  endfunction

  assign bus.fpu_data_in   = fpu_res(bus.op_a_out, bus.op_b_out);
  assign bus.fpu_status_in = fpu_stat(bus.op_a_out, bus.op_b_out);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", tag, obs, cyc);
    end
  endtask

  // Scoreboard: record accepted pushes, compare each consumed result in push order.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) sb.push_back({bus.in_a, bus.in_b});
      if (bus.res_valid && bus.res_ready) begin
        results_seen++;
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("order_data", bus.res_data, fpu_res(e[63:32], e[31:0]));
          check_eq("order_status", 32'(bus.res_status), 32'(fpu_stat(e[63:32], e[31:0])));
        end
      end
      if (int'(bus.count) > max_count) max_count = int'(bus.count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [31:0] a, input logic [31:0] b, output int n);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check_eq("push_timeout", 32'd1, 32'd0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_busy(output int c);
    int n = 0;
    while (!bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_eq("busy_timeout", 32'd1, 32'd0);
    c = cyc;
  endtask

  task automatic wait_res(output int c);
    int n = 0;
    while (!bus.res_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_eq("res_timeout", 32'd1, 32'd0);
    c = cyc;
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.busy || bus.count != '0) && n < 3000) begin
      tick();
      n++;
    end
    check_eq("drain_done", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int c0, c1, n;
    logic stable, refused, seen;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_op_a", bus.op_a_out, 32'd0);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_count", 32'(bus.count), 32'd0);
    tick();
    rst = 1'b0;
    check_eq("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Single op: 2.0 + 2.0, result valid 65 cycles after the pop
    push1(32'h4000_0000, 32'h4000_0000);
    wait_busy(c0);
    wait_res(c1);
    check_eq("single_latency", 32'(c1 - c0), 32'd65);
    check_eq("single_data", bus.res_data, 32'h4200_0000);
    check_eq("single_status", 32'(bus.res_status), 32'b0001);
    check_eq("single_op_a", bus.op_a_out, 32'h4000_0000);

    // Backpressure: 200 cycles in OUT with a second pair queued
    push1(32'h3f80_0000, 32'h4000_0000);
    stable = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== 32'h4200_0000 || bus.res_status !== 4'b0001 ||
          bus.op_a_out !== 32'h4000_0000 || bus.count !== 3'd1) stable = 1'b0;
    end
    check_eq("bp_stable", 32'(stable), 32'd1);
    tick();
    c0 = cyc;
    release_res();
    check_eq("bp_released", 32'(bus.res_valid), 32'd0);
    wait_busy(c1);
    check_eq("bp_next_pop", 32'(c1 - c0), 32'd2);
    wait_res(c1);
    check_eq("second_data", bus.res_data, 32'h3d80_0000);
    check_eq("second_status", 32'(bus.res_status), 32'b0010);
    release_res();

    // Fill/full with the consumer always ready
    bus.res_ready = 1'b1;
    push1(32'h1000_0000, 32'd0);
    wait_busy(c0);
    for (int i = 1; i <= 4; i++) begin
      push_wait(32'h1000_0000 + 32'(i), 32'(i), n);
      check_eq("fill_no_stall", 32'(n), 32'd0);
    end
    check_eq("full_count", 32'(bus.count), 32'd4);
    check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
    push_wait(32'h1000_0005, 32'd5, n);
    check_eq("fifth_waited", 32'(n > 10), 32'd1);
    check_eq("refill_count", 32'(bus.count), 32'd4);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h1000_0006;
    bus.in_b     = 32'd6;
    refused = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.in_ready || bus.count !== 3'd4) refused = 1'b0;
    end
    tick();
    bus.in_valid = 1'b0;
    check_eq("sixth_refused", 32'(refused), 32'd1);
    drain();

    // Ordering across pointer wrap
    for (int i = 0; i < 10; i++) push_wait(32'(i) << 25, 32'd0, n);
    drain();

    // Push on the same edge as the IDLE pop at count=1
    push1(32'h1111_1111, 32'h2222_2222);
    push1(32'h3333_3333, 32'h4444_4444);
    check_eq("simul_count", 32'(bus.count), 32'd1);
    check_eq("simul_op_a", bus.op_a_out, 32'h1111_1111);
    drain();
    check_eq("simul_next_op_a", bus.op_a_out, 32'h3333_3333);
    check_eq("results_total", 32'(results_seen), 32'd20);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    check_eq("max_count", 32'(max_count), 32'd4);

    // Reset while in WAIT with three entries queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_wait(32'hA000_0000 + 32'(i), 32'h0B00_0000, n);
    repeat (10) tick();
    check_eq("pre_rst_count", 32'(bus.count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("async_op_a", bus.op_a_out, 32'd0);
    check_eq("async_op_b", bus.op_b_out, 32'd0);
    check_eq("async_busy", 32'(bus.busy), 32'd0);
    check_eq("async_count", 32'(bus.count), 32'd0);
    check_eq("async_res", {bus.res_data[27:0], bus.res_status}, 32'd0);
    sb.delete();
    repeat (3) tick();
    rst = 1'b0;
    check_eq("in_ready_after_rst2", 32'(bus.in_ready), 32'd1);
    bus.res_ready = 1'b1;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) seen = 1'b1;
    end
    check_eq("no_res_after_rst", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning operand-pair FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 64, meaning cycles operands are held on the FPU before capture (legal range 16..255).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset:
- clock100KHz  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- in_valid  in  1  an operand pair is offered.
- in_ready  out  1  FIFO can accept; equals not-full.
- in_a  in  32  operand A {sign, exp[5:0], mant[24:0]}.
- in_b  in  32  operand B, same format.
- op_a_out  out  32  registered operand A driven to the FPU.
- op_b_out  out  32  registered operand B driven to the FPU.
- fpu_data_in  in  32  FPU result word.
- fpu_status_in  in  4  FPU status (0001 exact, 0010 inexact, 0100 overflow, 1000 underflow).
- res_valid  out  1  captured result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  captured result.
- res_status  out  4  captured status.
- busy  out  1  high whenever the FSM is not in IDLE.
- count  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-005 A push SHALL occur on a rising edge when in_valid and in_ready are both 1; {in_a, in_b} is written at the write pointer.
REQ-006 in_ready SHALL be combinational !full; a push when full SHALL be impossible, and in_a/in_b SHALL be ignored while in_ready=0.
REQ-007 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from count, which SHALL range 0..DEPTH.
REQ-008 A push and a pop on the same edge SHALL leave count unchanged; a pop SHALL be requested only when count>0 at the start of that cycle.
REQ-009 The FSM SHALL have states IDLE, ISSUE, WAIT, CAPTURE and OUT.
REQ-010 IDLE: if count>0, the FSM SHALL pop the head entry into op_a_out/op_b_out and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-011 ISSUE: the block SHALL load the timer with HOLD_CYCLES-2 and go to WAIT (ISSUE lasts one cycle).
REQ-012 WAIT: the timer SHALL decrement each cycle; when the timer is 0 the FSM SHALL go to CAPTURE.
REQ-013 CAPTURE: the block SHALL register fpu_data_in into res_data and fpu_status_in into res_status, set res_valid=1 and go to OUT.
REQ-014 Because the FPU recomputes continuously on stable operands, capture SHALL occur exactly HOLD_CYCLES cycles after op_a_out/op_b_out change, so at least two full FPU passes have settled.
REQ-015 OUT: res_valid, res_data and res_status SHALL remain stable until an edge where res_ready=1; on that edge res_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-016 op_a_out/op_b_out SHALL change only on the IDLE-to-ISSUE pop and SHALL hold their value in every other state, including OUT and IDLE.
REQ-017 Latency from a pop to res_valid=1 SHALL be HOLD_CYCLES+1 cycles; minimum issue interval SHALL be HOLD_CYCLES+3 cycles with res_ready tied high.
REQ-018 Pushes SHALL be accepted in every FSM state.
REQ-019 res_ready while res_valid=0 SHALL have no effect.
REQ-020 The block SHALL not inspect or alter result contents: sign, exponent and status SHALL pass through bit-exact.

Reset
REQ-021 While reset=1, the block SHALL immediately (asynchronously) force: FSM to IDLE, pointers/count/timer to 0, op_a_out=op_b_out=0, res_data=0, res_status=0, res_valid=0, busy=0.
REQ-022 Reset asserted mid-operation (any state) SHALL discard all FIFO contents and any in-flight result without a res_valid pulse.
REQ-023 After reset deasserts, in_ready SHALL be 1 on the first cycle.

Verification
REQ-024 Single op: push A=0x40000000, B=0x40000000; FPU model returns 0x42000000 with status 0001 -> res_valid rises 65 cycles after the pop, with res_data=0x42000000 and res_status=0001.
REQ-025 Fill/full: push 5 pairs back-to-back with DEPTH=4 while the first is in WAIT -> the 5th is accepted only after the pop frees a slot; count never exceeds 4; the 6th is refused while full.
REQ-026 Backpressure: hold res_ready=0 for 200 cycles in OUT -> res_data, res_status and op_a_out stay constant and no new pop occurs; releasing res_ready -> next pop 2 cycles later.
REQ-027 Ordering/wrap: push 10 distinct pairs (A=i<<25, B=0) -> results emerge in push order across pointer wrap.
REQ-028 Simultaneous events: push on the same edge as the IDLE pop at count=1 -> count remains 1 and the new entry is issued next.
REQ-029 Reset in WAIT with 3 entries queued -> all outputs are 0 immediately; count=0; no res_valid is observed afterward without new pushes.
